// File: rtl/ifu_prefetch_if.sv
// Instruction-side AXI4-lite read channel between
// the prefetcher (master) and the fetch arbiter (slave).
interface ifu_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [2:0]        arsize;
  logic [INST_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arvalid, arsize, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, arsize, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: one AXI4-lite read in flight,
// DEPTH-entry buffer toward the IDU, redirect flushes and drains.
module ifu_prefetch #(
  parameter int              ADDR_W   = 32,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  ifu_prefetch_if.master    axi,
  output logic              valid_out_idu,
  input  logic              ready_in_idu,
  output logic [ADDR_W-1:0] pc_out,
  output logic [INST_W-1:0] inst_out,
  output logic              fault_out
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE, ADDR, DATA, DRAIN
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic [ADDR_W-1:0] araddr_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              pend_q;

  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [DEPTH-1:0]  flt_mem_q;
  logic [PW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [ADDR_W-1:0] redir_pc;
  logic              ar_hs, r_hs;
  logic              push, pop;

  assign redir_pc = redirect_pc & ~ADDR_W'(3);
  assign ar_hs    = arvalid_q & axi.arready;
  assign r_hs     = rready_q & axi.rvalid;
  assign push     = (state_q == DATA) & r_hs
                  & !redirect_valid;
  assign pop      = valid_out_idu & ready_in_idu;
  assign cnt_d    = cnt_q + CW'(push) - CW'(pop);

  assign axi.araddr  = araddr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.arsize  = 3'b010;
  assign axi.rready  = rready_q;

  assign valid_out_idu = (cnt_q != '0) & !redirect_valid;
  assign pc_out        = pc_mem_q[rd_q];
  assign inst_out      = inst_mem_q[rd_q];
  assign fault_out     = flt_mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      araddr_q   <= RESET_PC;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      if (redirect_valid)
        fetch_pc_q <= redir_pc;
      unique case (state_q)
        IDLE: begin
          if (!redirect_valid && cnt_q < FULL) begin
            state_q   <= ADDR;
            araddr_q  <= fetch_pc_q;
            req_pc_q  <= fetch_pc_q;
            arvalid_q <= 1'b1;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            pend_q    <= 1'b0;
            if (redirect_valid || pend_q) begin
              state_q <= DRAIN;
            end else begin
              state_q    <= DATA;
              fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
            end
          end else if (redirect_valid) begin
            // araddr must stay put; remember the request is stale
            pend_q <= 1'b1;
          end
        end
        DATA: begin
          if (r_hs) begin
            rready_q <= 1'b0;
            if (!redirect_valid && cnt_d < FULL) begin
              state_q   <= ADDR;
              araddr_q  <= fetch_pc_q;
              req_pc_q  <= fetch_pc_q;
              arvalid_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else if (redirect_valid) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_hs) begin
            rready_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      flt_mem_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        pc_mem_q[wr_q]   <= req_pc_q;
        inst_mem_q[wr_q] <= axi.rdata;
        flt_mem_q[wr_q]  <= |axi.rresp;
        wr_q             <= wr_q + PW'(1);
      end
      if (pop)
        rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  a_no_push_full: assert property (
    @(posedge clk) disable iff (rst)
    !(push && cnt_q == FULL));

  a_no_pop_empty: assert property (
    @(posedge clk) disable iff (rst)
    !(pop && cnt_q == '0));
endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: AXI slave model, IDU monitor,
// directed redirect / backpressure / fault / wrap / reset cases.
module tb_ifu_prefetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        valid_out_idu;
  logic        ready_in_idu;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        fault_out;

  ifu_prefetch_if #(.ADDR_W(32), .INST_W(32)) axi();

  ifu_prefetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .axi            (axi),
    .valid_out_idu  (valid_out_idu),
    .ready_in_idu   (ready_in_idu),
    .pc_out         (pc_out),
    .inst_out       (inst_out),
    .fault_out      (fault_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        f;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ar_log[$];
  int          pop_t[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  int          ar_lat = 0;
  int          r_lat = 0;
  logic [31:0] err_addr = 32'h1;

  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return axi.arvalid;
      1:       return axi.rready;
      2:       return valid_out_idu;
      default: return exp_q.size() == 0;
    endcase
  endfunction

  task automatic wait_for(input string name, input int s,
                          input int budget);
    int n = 0;
    while (!sig(s) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!sig(s)) begin
      n_bad++;
      $display("FAIL timeout_%s actual=0 required=1", name);
    end
  endtask

  task automatic expect_seq(input logic [31:0] start,
                            input int n);
    exp_t e;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + 32'(4 * i);
      e.pc = a;
      e.inst = ~a;
      e.f = (a == err_addr);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    ready_in_idu = 1'b0;
    repeat (2) @(negedge clk);
    ar_log.delete();
    pop_t.delete();
    rst = 1'b0;
  endtask

  // AXI slave: drive for the current cycle at each falling edge
  initial begin
    logic        r_have, hold_v;
    logic [31:0] r_addr, hold_a;
    int          r_cnt, ar_wait;
    r_have = 0; hold_v = 0; r_cnt = 0; ar_wait = 0;
    r_addr = '0; hold_a = '0;
    axi.arready = 0; axi.rvalid = 0;
    axi.rdata = '0; axi.rresp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_have = 0; ar_wait = 0; hold_v = 0;
        axi.arready = 0; axi.rvalid = 0;
      end else begin
        if (r_have && r_cnt == 0) begin
          axi.rvalid = 1;
          axi.rdata = ~r_addr;
          axi.rresp = (r_addr == err_addr) ? 2'b10 : 2'b00;
          if (axi.rready) r_have = 0;
        end else begin
          axi.rvalid = 0;
          if (r_have) r_cnt--;
        end
        if (hold_v) begin
          chk("arvalid_hold", 32'(axi.arvalid), 32'd1);
          chk("araddr_hold", axi.araddr, hold_a);
        end
        if (axi.arvalid) begin
          axi.arready = (ar_wait >= ar_lat);
          if (axi.arready) begin
            ar_log.push_back(axi.araddr);
            r_have = 1; r_addr = axi.araddr;
            r_cnt = r_lat; ar_wait = 0; hold_v = 0;
          end else begin
            ar_wait++; hold_v = 1; hold_a = axi.araddr;
          end
        end else begin
          axi.arready = 0; ar_wait = 0; hold_v = 0;
        end
      end
    end
  end

  // IDU monitor: every accepted head is checked against the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (valid_out_idu && ready_in_idu) begin
        pop_t.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pop actual=%h required=none",
                   pc_out);
        end else begin
          e = exp_q.pop_front();
          chk("pc_out", pc_out, e.pc);
          chk("inst_out", inst_out, e.inst);
          chk("fault_out", 32'(fault_out), 32'(e.f));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=done");
    $fatal(1, "watchdog");
  end

  initial begin
    redirect_pc = '0;
    // reset values, then the IDLE -> ADDR step
    rst = 1'b1;
    redirect_valid = 1'b0;
    ready_in_idu = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_araddr", axi.araddr, 32'h8000_0000);
    chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
    chk("rst_rready", 32'(axi.rready), 32'd0);
    chk("rst_valid", 32'(valid_out_idu), 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_inst", inst_out, 32'd0);
    chk("rst_fault", 32'(fault_out), 32'd0);
    chk("arsize", 32'(axi.arsize), 32'd2);
    ar_log.delete();
    pop_t.delete();
    rst = 1'b0;
    ready_in_idu = 1'b1;
    @(negedge clk);
    chk("first_arvalid", 32'(axi.arvalid), 32'd1);
    chk("first_araddr", axi.araddr, 32'h8000_0000);

    // zero-wait streaming
    expect_seq(32'h8000_0000, 6);
    wait_for("stream", 3, 60);
    ready_in_idu = 1'b0;
    chk("stream_ar_n", 32'(ar_log.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++)
      chk("stream_araddr", ar_log[i],
          32'h8000_0000 + 32'(4 * i));
    chk("stream_rate", 32'(pop_t[5] - pop_t[0]), 32'd10);

    // backpressure: fill to DEPTH, then drain in order
    do_reset();
    repeat (20) @(negedge clk);
    chk("full_ar_n", 32'(ar_log.size()), 32'd4);
    chk("full_arvalid", 32'(axi.arvalid), 32'd0);
    chk("full_valid", 32'(valid_out_idu), 32'd1);
    chk("full_head", pc_out, 32'h8000_0000);
    expect_seq(32'h8000_0000, 5);
    ready_in_idu = 1'b1;
    wait_for("drain", 3, 60);
    ready_in_idu = 1'b0;
    chk("resume_araddr", ar_log[4], 32'h8000_0010);

    // redirect in DATA with a slow response
    do_reset();
    r_lat = 3;
    ready_in_idu = 1'b1;
    wait_for("data_wait", 1, 20);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
    r_lat = 0;
    chk("redir_empty", 32'(valid_out_idu), 32'd0);
    expect_seq(32'h8000_0100, 3);
    wait_for("redir_data", 3, 80);
    ready_in_idu = 1'b0;
    chk("redir_ar0", ar_log[0], 32'h8000_0000);
    chk("redir_ar1", ar_log[1], 32'h8000_0100);

    // redirect in ADDR while arready is low; last target wins
    do_reset();
    ar_lat = 2;
    ready_in_idu = 1'b1;
    wait_for("addr_wait", 0, 20);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0300;
    @(negedge clk);
    redirect_pc = 32'h8000_0200;
    chk("addr_hold", axi.araddr, 32'h8000_0000);
    @(negedge clk);
    redirect_valid = 1'b0;
    expect_seq(32'h8000_0200, 2);
    wait_for("redir_addr", 3, 80);
    ready_in_idu = 1'b0;
    ar_lat = 0;
    chk("addr_ar0", ar_log[0], 32'h8000_0000);
    chk("addr_ar1", ar_log[1], 32'h8000_0200);

    // error response on one fetch
    do_reset();
    err_addr = 32'h8000_0008;
    ready_in_idu = 1'b1;
    expect_seq(32'h8000_0000, 5);
    wait_for("fault", 3, 60);
    ready_in_idu = 1'b0;
    err_addr = 32'h1;

    // redirect in IDLE, then wrap past the top of memory
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF9;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("idle_redir", 32'(axi.arvalid), 32'd0);
    ready_in_idu = 1'b1;
    expect_seq(32'hFFFF_FFF8, 4);
    wait_for("wrap", 3, 60);
    ready_in_idu = 1'b0;
    chk("wrap_ar", ar_log[2], 32'h0000_0000);

    // reset in the middle of a read
    do_reset();
    wait_for("mid_valid", 2, 20);
    wait_for("mid_data", 1, 20);
    chk("mid_head", inst_out, 32'h7FFF_FFFF);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_araddr", axi.araddr, 32'h8000_0000);
    chk("mid_arvalid", 32'(axi.arvalid), 32'd0);
    chk("mid_rready", 32'(axi.rready), 32'd0);
    chk("mid_valid", 32'(valid_out_idu), 32'd0);
    chk("mid_pc", pc_out, 32'd0);
    chk("mid_inst", inst_out, 32'd0);
    chk("mid_fault", 32'(fault_out), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("left_exp", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
